// File: rtl/swap_reverse_seq_if.sv
// Swap command bus between the region-reverse sequencer and its controller.
//   master : the sequencer. It sees start/base_addr/len/abort and drives the
//            swap command (addr_A, addr_B, swap) plus the busy/done/swap_count status.
//   slave  : the controller side. It drives the request and observes the rest.
interface swap_reverse_seq_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   len;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] addr_A;
  logic [ADDR_WIDTH-1:0] addr_B;
  logic                  swap;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] swap_count;

  modport master (
    input  start, base_addr, len, abort,
    output addr_A, addr_B, swap, busy, done, swap_count
  );

  modport slave (
    output start, base_addr, len, abort,
    input  addr_A, addr_B, swap, busy, done, swap_count
  );
endinterface

// File: rtl/swap_reverse_seq.sv
// Reverses the region [base_addr, base_addr+len-1] of a swap-capable register
// file in place. It swaps the outermost pair first and moves inward. Each swap
// pulse is followed by a window of SWAP_CYCLES cycles in which the addresses
// stay stable.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : swap_reverse_seq_if.master
//           (start/base_addr/len/abort in; addr_A/addr_B/swap/busy/done/swap_count out)
// Every output is registered. Each output register is loaded from the value
// computed for the next state, so the outputs seen in a cycle belong to the
// state the FSM is in during that cycle.
module swap_reverse_seq #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SWAP_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  swap_reverse_seq_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam int            CW       = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SWAP_CYCLES - 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_lo, w_lo_nxt;
  logic [ADDR_WIDTH-1:0] r_hi, w_hi_nxt;
  logic [ADDR_WIDTH-1:0] r_rem, w_rem_nxt;
  logic [ADDR_WIDTH-1:0] r_count, w_count_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_abort_pend, w_abort_nxt;
  logic                  r_swap, r_busy, r_done;
  logic [ADDR_WIDTH-1:0] r_addr_a, r_addr_b;

  logic                  w_adv;
  logic                  w_busy_nxt;
  logic [ADDR_WIDTH:0]   w_end;

  // Last address of the region. It is truncated to ADDR_WIDTH bits, so a
  // region that runs past the top of the address space wraps to 0.
  assign w_end = {1'b0, bus.base_addr} + bus.len - (ADDR_WIDTH+1)'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_rem_nxt   = r_rem;
    w_count_nxt = r_count;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = r_abort_pend;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_lo_nxt    = bus.base_addr;
          w_hi_nxt    = w_end[ADDR_WIDTH-1:0];
          w_rem_nxt   = bus.len[ADDR_WIDTH:1];
          w_count_nxt = '0;
          w_abort_nxt = 1'b0;
          w_state_nxt = (bus.len < (ADDR_WIDTH+1)'(2)) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = CNT_LOAD;
        w_abort_nxt = r_abort_pend | bus.abort;
        if (SWAP_CYCLES == 1) w_adv = 1'b1;
        else                  w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_abort_nxt = r_abort_pend | bus.abort;
        // The counter enters WAIT at SWAP_CYCLES-1 and is always at least 1.
        // The advance happens on the cycle where it reads 1, which closes the
        // window of exactly SWAP_CYCLES cycles.
        if (r_cnt > CW'(1)) w_cnt_nxt = r_cnt - CW'(1);
        else                w_adv     = 1'b1;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_adv) begin
      w_lo_nxt    = r_lo + ADDR_WIDTH'(1);
      w_hi_nxt    = r_hi - ADDR_WIDTH'(1);
      w_rem_nxt   = r_rem - ADDR_WIDTH'(1);
      w_count_nxt = r_count + ADDR_WIDTH'(1);
      // An abort seen during the window only takes effect here, after the
      // current swap has had its full window.
      w_state_nxt = ((r_rem == ADDR_WIDTH'(1)) || r_abort_pend || bus.abort) ? S_DONE : S_ISSUE;
    end
  end

  assign w_busy_nxt = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lo         <= '0;
      r_hi         <= '0;
      r_rem        <= '0;
      r_count      <= '0;
      r_cnt        <= '0;
      r_abort_pend <= 1'b0;
      r_swap       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_addr_a     <= '0;
      r_addr_b     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_lo         <= w_lo_nxt;
      r_hi         <= w_hi_nxt;
      r_rem        <= w_rem_nxt;
      r_count      <= w_count_nxt;
      r_cnt        <= w_cnt_nxt;
      r_abort_pend <= w_abort_nxt;
      r_swap       <= (w_state_nxt == S_ISSUE);
      r_busy       <= w_busy_nxt;
      r_done       <= (w_state_nxt == S_DONE);
      // lo/hi do not change during WAIT, so the pair stays on the bus for the
      // whole window. The bus shows 0 outside a run.
      r_addr_a     <= w_busy_nxt ? w_lo_nxt : '0;
      r_addr_b     <= w_busy_nxt ? w_hi_nxt : '0;
    end
  end

  assign bus.swap       = r_swap;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.addr_A     = r_addr_a;
  assign bus.addr_B     = r_addr_b;
  assign bus.swap_count = r_count;

endmodule

// File: tb/tb_swap_reverse_seq.sv
module tb_swap_reverse_seq;
  localparam int AW   = 7;
  localparam int MASK = (1 << AW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  swap_reverse_seq_if #(.ADDR_WIDTH(AW)) bus3 ();
  swap_reverse_seq_if #(.ADDR_WIDTH(AW)) bus1 ();

  swap_reverse_seq #(.ADDR_WIDTH(AW), .SWAP_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3.master));
  swap_reverse_seq #(.ADDR_WIDTH(AW), .SWAP_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

  // Observed outputs packed as {swap, busy, done, addr_A, addr_B, swap_count}.
  logic [3*AW+2:0] w_obs3, w_obs1;
  assign w_obs3 = {bus3.swap, bus3.busy, bus3.done, bus3.addr_A, bus3.addr_B, bus3.swap_count};
  assign w_obs1 = {bus1.swap, bus1.busy, bus1.done, bus1.addr_A, bus1.addr_B, bus1.swap_count};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input int b, input int l, input logic ab);
    bus3.start = st; bus3.base_addr = AW'(b); bus3.len = (AW+1)'(l); bus3.abort = ab;
    bus1.start = st; bus1.base_addr = AW'(b); bus1.len = (AW+1)'(l); bus1.abort = ab;
  endtask

  // Reference model. It gives the expected outputs r cycles after the cycle
  // in which start was accepted.
  // The run has P = len/2 swaps. Swap k owns cycles 1+k*sc .. (k+1)*sc. An
  // abort at cycle ra inside the busy span lets the swap that owns cycle ra
  // finish, and no later swap is issued.
  function automatic logic [3*AW+2:0] exp_vec(input int sc, input int r, input int base,
                                              input int len, input int ra);
    int p, pe, k, a, b, c;
    logic sw, bz, dn;
    p  = len / 2;
    pe = p;
    if (ra >= 1 && ra <= p * sc) pe = (ra - 1) / sc + 1;
    sw = 0; bz = 0; dn = 0; a = 0; b = 0; c = pe;
    if (r <= pe * sc) begin
      k  = (r - 1) / sc;
      sw = ((r - 1) % sc) == 0;
      bz = 1;
      a  = (base + k) & MASK;
      b  = (base + len - 1 - k) & MASK;
      c  = k;
    end else if (r == pe * sc + 1) begin
      dn = 1;
    end
    return {sw, bz, dn, AW'(a), AW'(b), AW'(c)};
  endfunction

  // One run on both DUTs (SWAP_CYCLES 3 and 1). The same inputs go to both.
  //   ra : cycle of a one-cycle abort pulse (0 = none)
  //   sb : if set, pulse start again at cycle 2, while the run is busy
  //   rr : if nonzero, assert reset after checking cycle rr
  task automatic run(input int base, input int len, input int ra, input bit sb, input int rr);
    int rmax;
    rmax = (len / 2) * 3 + 3;
    drive(1'b1, base, len, 1'b0);
    for (int r = 1; r <= rmax; r++) begin
      @(posedge clk); #1;
      chk($sformatf("sc3 b=%0d l=%0d ra=%0d r=%0d", base, len, ra, r), 32'(w_obs3), 32'(exp_vec(3, r, base, len, ra)));
      chk($sformatf("sc1 b=%0d l=%0d ra=%0d r=%0d", base, len, ra, r), 32'(w_obs1), 32'(exp_vec(1, r, base, len, ra)));
      if (rr != 0 && r == rr) begin
        reset = 1'b1;
        drive(1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        chk("sc3 midrun reset", 32'(w_obs3), 32'd0);
        chk("sc1 midrun reset", 32'(w_obs1), 32'd0);
        reset = 1'b0;
        break;
      end
      if (sb && r == 2 && len >= 2) drive(1'b1, (base + 40) & MASK, 2, r == ra);
      else                          drive(1'b0, base, len, r == ra);
    end
    drive(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int b, l, p, ra;
    bit sb;
    reset = 1'b1;
    drive(1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("sc3 reset state", 32'(w_obs3), 32'd0);
    chk("sc1 reset state", 32'(w_obs1), 32'd0);
    // Hold start and abort high during reset: nothing may leak through.
    drive(1'b1, 9, 4, 1'b1);
    @(posedge clk); #1;
    chk("sc3 reset holds", 32'(w_obs3), 32'd0);
    chk("sc1 reset holds", 32'(w_obs1), 32'd0);
    drive(1'b0, 0, 0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    run(10, 4, 0, 0, 0);     // basic run
    run(0, 5, 0, 0, 0);      // odd length, middle element never addressed
    run(0, 1, 0, 0, 0);      // degenerate lengths
    run(0, 0, 0, 0, 0);
    run(126, 4, 0, 0, 0);    // address wrap
    run(0, 8, 2, 1, 0);      // abort, with start re-pulsed while busy
    run(0, 6, 0, 0, 0);
    run(5, 128, 0, 0, 0);    // full address space
    run(3, 128, 100, 0, 0);
    run(20, 10, 0, 0, 2);    // reset in the middle of a run
    run(20, 10, 0, 0, 0);    // fresh run after the reset

    for (int i = 0; i < 25; i++) begin
      b  = int'($urandom_range(0, MASK));
      l  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 128)) : int'($urandom_range(0, 12));
      p  = l / 2;
      ra = ($urandom_range(0, 2) == 0 && p > 0) ? int'($urandom_range(1, p * 3)) : 0;
      sb = 1'($urandom_range(0, 1));
      run(b, l, ra, sb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
